// File: rtl/systolic_feeder_3x3.sv
// Operand store and skewed stream generator feeding a 3x3 output-stationary systolic array.
// Loads A/B over a valid/ready port, then on start emits clear, skewed rows/columns, and a done pulse.
module systolic_feeder_3x3 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [1:0]        ld_row,
  input  logic [1:0]        ld_col,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  output logic              busy,
  output logic              arr_clr,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2,
  output logic [DATA_W-1:0] b3,
  output logic              result_valid
);

  localparam int unsigned N      = 3;
  localparam int unsigned T_W    = 3;
  localparam logic [T_W-1:0] T_LAST = T_W'(2 * (N - 1) + 2);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t           state, state_n;
  logic [T_W-1:0]   t, t_n;
  logic [DATA_W-1:0] mem_a [N][N];
  logic [DATA_W-1:0] mem_b [N][N];
  logic [DATA_W-1:0] a_q [N];
  logic [DATA_W-1:0] b_q [N];
  logic [DATA_W-1:0] a_n [N];
  logic [DATA_W-1:0] b_n [N];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
    end
  end

  // Next-state logic; t counts feed cycles 0..T_LAST
  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE:  if (start) state_n = CLEAR;
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        if (t == T_LAST) state_n = DONE;
        else             t_n = t + T_W'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stream values for the upcoming cycle; row i lags by i cycles, column j by j cycles
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_n[i] = '0;
      b_n[i] = '0;
    end
    if (state_n == FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (t_n >= T_W'(i) && (t_n - T_W'(i)) <= T_W'(N - 1)) begin
          a_n[i] = mem_a[2'(i)][2'(t_n - T_W'(i))];
          b_n[i] = mem_b[2'(t_n - T_W'(i))][2'(i)];
        end
      end
    end
  end

  // Operand storage; out-of-range indices complete the handshake but are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          mem_a[i][j] <= '0;
          mem_b[i][j] <= '0;
        end
      end
    end else if (ld_valid && ld_ready && ld_row != 2'd3 && ld_col != 2'd3) begin
      if (ld_sel) mem_b[ld_row][ld_col] <= ld_data;
      else        mem_a[ld_row][ld_col] <= ld_data;
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_ready     <= 1'b1;
      busy         <= 1'b0;
      arr_clr      <= 1'b0;
      result_valid <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      ld_ready     <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
      arr_clr      <= (state_n == CLEAR);
      result_valid <= (state_n == DONE);
      for (int unsigned i = 0; i < N; i++) begin
        a_q[i] <= a_n[i];
        b_q[i] <= b_n[i];
      end
    end
  end

  assign a1 = a_q[0];
  assign a2 = a_q[1];
  assign a3 = a_q[2];
  assign b1 = b_q[0];
  assign b2 = b_q[1];
  assign b3 = b_q[2];

endmodule
